// File: rtl/rst_seq_pkg.sv
// Shared definitions for the reset sequencer: parameter defaults and FSM state encoding.
package rst_seq_pkg;

  localparam int unsigned LOCK_STABLE_CYC_DEF = 1024;
  localparam int unsigned DEBOUNCE_CYC_DEF    = 256;
  localparam int unsigned STAGE_GAP_CYC_DEF   = 16;
  localparam int unsigned NUM_STAGES_DEF      = 3;

  typedef logic [1:0] state_t;

  localparam state_t S_WAIT_LOCK = 2'd0;
  localparam state_t S_RELEASE   = 2'd1;
  localparam state_t S_RUN       = 2'd2;

endpackage

// File: rtl/rst_bit_sync.sv
// Two-flop synchronizer for a single asynchronous level, cleared to 0 by the async reset.
module rst_bit_sync (
  input  logic clk,
  input  logic async_nrst_i,
  input  logic d,
  output logic q
);

  logic meta;

  // Sample the asynchronous input twice to resolve metastability.
  always_ff @(posedge clk or negedge async_nrst_i) begin
    if (!async_nrst_i) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/rst_sequencer.sv
// Staged reset release: waits for a stable PLL lock and a released console button,
// then deasserts the per-stage active-low resets in ascending order, one gap apart.
module rst_sequencer
  import rst_seq_pkg::*;
#(
  parameter int unsigned LOCK_STABLE_CYC = LOCK_STABLE_CYC_DEF,
  parameter int unsigned DEBOUNCE_CYC    = DEBOUNCE_CYC_DEF,
  parameter int unsigned STAGE_GAP_CYC   = STAGE_GAP_CYC_DEF,
  parameter int unsigned NUM_STAGES      = NUM_STAGES_DEF
) (
  input  logic                  clk,
  input  logic                  async_nrst_i,
  input  logic                  pll_locked_i,
  input  logic                  nrst_btn_i,
  output logic [NUM_STAGES-1:0] nrst_o,
  output logic                  seq_done_o
);

  localparam int unsigned SW = $clog2(LOCK_STABLE_CYC);
  localparam int unsigned DW = $clog2(DEBOUNCE_CYC);
  localparam int unsigned GW = $clog2(STAGE_GAP_CYC + 1);

  localparam logic [SW-1:0]         STABLE_LAST = SW'(LOCK_STABLE_CYC - 1);
  localparam logic [DW-1:0]         DEB_LAST    = DW'(DEBOUNCE_CYC - 1);
  localparam logic [GW-1:0]         GAP_LAST    = GW'(STAGE_GAP_CYC - 1);
  localparam logic [NUM_STAGES-1:0] FIRST_STAGE = NUM_STAGES'(1);

  logic                  lock_s;
  logic                  btn_s;
  logic                  btn_db;
  logic [DW-1:0]         deb_cnt;
  logic [SW-1:0]         stable_cnt;
  logic [GW-1:0]         gap_cnt;
  state_t                state;
  logic                  abort;
  logic [NUM_STAGES-1:0] nrst_next;

  rst_bit_sync u_lock_sync (
    .clk          (clk),
    .async_nrst_i (async_nrst_i),
    .d            (pll_locked_i),
    .q            (lock_s)
  );

  rst_bit_sync u_btn_sync (
    .clk          (clk),
    .async_nrst_i (async_nrst_i),
    .d            (nrst_btn_i),
    .q            (btn_s)
  );

  // Abort condition and the next staged-release pattern (one more bit released).
  always_comb begin
    abort     = ~lock_s | ~btn_db;
    nrst_next = (nrst_o << 1) | FIRST_STAGE;
  end

  // Button debounce: adopt btn_s only after it has differed for DEBOUNCE_CYC edges.
  // Not cleared by an abort, otherwise a pressed button could never be seen released.
  always_ff @(posedge clk or negedge async_nrst_i) begin
    if (!async_nrst_i) begin
      btn_db  <= 1'b1;
      deb_cnt <= '0;
    end else if (btn_s == btn_db) begin
      deb_cnt <= '0;
    end else if (deb_cnt == DEB_LAST) begin
      btn_db  <= btn_s;
      deb_cnt <= '0;
    end else begin
      deb_cnt <= deb_cnt + 1'b1;
    end
  end

  // Sequencer FSM: lock-stable wait, gapped stage release, then run until abort.
  always_ff @(posedge clk or negedge async_nrst_i) begin
    if (!async_nrst_i) begin
      state      <= S_WAIT_LOCK;
      stable_cnt <= '0;
      gap_cnt    <= '0;
      nrst_o     <= '0;
      seq_done_o <= 1'b0;
    end else if (abort) begin
      state      <= S_WAIT_LOCK;
      stable_cnt <= '0;
      gap_cnt    <= '0;
      nrst_o     <= '0;
      seq_done_o <= 1'b0;
    end else begin
      case (state)
        S_WAIT_LOCK: begin
          if (stable_cnt == STABLE_LAST) begin
            stable_cnt <= '0;
            gap_cnt    <= '0;
            nrst_o     <= FIRST_STAGE;
            if (NUM_STAGES == 1) begin
              state      <= S_RUN;
              seq_done_o <= 1'b1;
            end else begin
              state <= S_RELEASE;
            end
          end else begin
            stable_cnt <= stable_cnt + 1'b1;
          end
        end
        S_RELEASE: begin
          if (gap_cnt == GAP_LAST) begin
            gap_cnt <= '0;
            nrst_o  <= nrst_next;
            if (&nrst_next) begin
              state      <= S_RUN;
              seq_done_o <= 1'b1;
            end
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        S_RUN: begin
          state <= S_RUN;
        end
        default: begin
          state      <= S_WAIT_LOCK;
          stable_cnt <= '0;
          gap_cnt    <= '0;
          nrst_o     <= '0;
          seq_done_o <= 1'b0;
        end
      endcase
    end
  end

endmodule
